hub75_scan: RTL

HUB75_SCAN -- requirements
Module: hub75_scan

---
 rtl/hub75_scan.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hub75_scan.sv
// HUB75 LED panel scan engine. Walks the panel row by row and, for each row,
// every bit plane from 0 to bpp_p-1: shifts one column per two clocks into the
// panel, latches the row, then lights it for a time that doubles with each bit
// plane (binary-coded modulation). All segments are driven in parallel.
module hub75_scan #(
  parameter int hpixel_p      = 64,
  parameter int vpixel_p      = 64,
  parameter int bpp_p         = 8,
  parameter int segments_p    = 2,
  parameter int base_cycles_p = 4,
  localparam int rows_p       = vpixel_p / segments_p,
  localparam int row_w        = $clog2(rows_p),
  localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_en,
  output logic [addr_width_p-1:0]           o_rd_addr,
  input  logic [segments_p*3*bpp_p-1:0]     i_rd_data,
  output logic [segments_p*3-1:0]           o_rgb,
  output logic                              o_clk,
  output logic                              o_lat,
  output logic                              o_oe,
  output logic [row_w-1:0]                  o_row,
  output logic                              o_frame_done
);

  localparam int col_w   = $clog2(hpixel_p);
  localparam int bit_w   = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int disp_w  = $clog2((base_cycles_p << (bpp_p - 1)) + 1);
  localparam int lanes_p = segments_p * 3;

  localparam logic [col_w:0] last_shift = (col_w + 1)'(2 * hpixel_p - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

  state_e              state;
  logic [row_w-1:0]    row_r;
  logic [bit_w-1:0]    bit_r;
  logic [col_w:0]      shift_cnt;   // {column, phase}; phase 1 is the o_clk-high half
  logic [disp_w-1:0]   disp_cnt;
  logic [lanes_p-1:0]  rgb_hold;
  logic [lanes_p-1:0]  plane_bits;

  logic                last_bit;
  logic                last_row;
  logic                enter_last_disp;
  logic [row_w-1:0]    row_next;
  logic [disp_w-1:0]   disp_len;
  logic [addr_width_p-1:0] next_base;

  assign last_bit  = (bit_r == bit_w'(bpp_p - 1));
  assign last_row  = (row_r == row_w'(rows_p - 1));
  assign row_next  = last_bit ? (last_row ? '0 : row_r + 1'b1) : row_r;
  assign disp_len  = disp_w'(base_cycles_p) << bit_r;
  assign next_base = addr_width_p'(row_next) * addr_width_p'(hpixel_p);

  // The clock edge that starts the final DISPLAY cycle; the next pass's first
  // address and the frame pulse are launched here so they line up exactly.
  assign enter_last_disp = ((state == LATCH)   && (disp_len == disp_w'(1))) ||
                           ((state == DISPLAY) && (disp_cnt == disp_w'(1)));

  // Select the current bit plane out of every segment/channel lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    plane_bits = '0;
    for (int i = 0; i < lanes_p; i++) begin
      plane_bits[i] = i_rd_data[i * bpp_p + int'(bit_r)];
    end
  end

  // Panel data: the source answers one cycle after the address, so in the first
  // half of a column the fresh data is passed straight through; the second half
  // (and every other state) shows the copy captured at the end of the first half.
  always_comb begin
    o_rgb = rgb_hold;
    if ((state == SHIFT) && !shift_cnt[0]) begin
      o_rgb = plane_bits;
    end
  end

  // Scan sequencer with registered panel and source-address outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state        <= IDLE;
      row_r        <= '0;
      bit_r        <= '0;
      shift_cnt    <= '0;
      disp_cnt     <= '0;
      rgb_hold     <= '0;
      o_rd_addr    <= '0;
      o_clk        <= 1'b0;
      o_lat        <= 1'b0;
      o_oe         <= 1'b1;
      o_row        <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_clk        <= 1'b0;
      o_lat        <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          o_oe      <= 1'b1;
          o_rd_addr <= '0;
          if (i_en) begin
            state     <= SHIFT;
            row_r     <= '0;
            bit_r     <= '0;
            shift_cnt <= '0;
          end
        end
        SHIFT: begin
          if (!shift_cnt[0]) begin
            shift_cnt <= shift_cnt + 1'b1;
            o_clk     <= 1'b1;
            rgb_hold  <= plane_bits;
            // Prefetch the next column; the last column's address is held.
            if (shift_cnt[col_w:1] != col_w'(hpixel_p - 1)) begin
              o_rd_addr <= o_rd_addr + 1'b1;
            end
          end else if (shift_cnt == last_shift) begin
            shift_cnt <= '0;
            state     <= LATCH;
            o_lat     <= 1'b1;
            o_row     <= row_r;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        LATCH: begin
          state    <= DISPLAY;
          o_oe     <= 1'b0;
          disp_cnt <= disp_len - 1'b1;
          if (enter_last_disp) begin
            o_rd_addr    <= next_base;
            o_frame_done <= last_bit && last_row;
          end
        end
        DISPLAY: begin
          if (disp_cnt == '0) begin
            o_oe  <= 1'b1;
            bit_r <= last_bit ? '0 : bit_r + 1'b1;
            row_r <= row_next;
            // i_en only matters at the frame boundary; a frame always completes.
            state <= (last_bit && last_row && !i_en) ? IDLE : SHIFT;
          end else begin
            disp_cnt <= disp_cnt - 1'b1;
            if (enter_last_disp) begin
              o_rd_addr    <= next_base;
              o_frame_done <= last_bit && last_row;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
